// File: rtl/parity_pkg.sv
// ---------------------------------------------------------------------------
// parity_pkg
// Shared definitions for the serial parity frame controller:
//   - state_t    : controller FSM states (IDLE, SHIFT, CHECK, HOLD)
//   - FRAME_BITS : serial bits per frame (4 data + 1 parity)
//   - DATA_BITS  : data bits per frame
//   - DIV_W      : width of the bit-period divider (BIT_DIV up to 255)
//   - IDX_W      : width of the bit index within a frame
//   - frame_data : extracts the nibble {d3,d2,d1,d0} from a captured frame
// ---------------------------------------------------------------------------
package parity_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam int FRAME_BITS = 5;
    localparam int DATA_BITS  = 4;
    localparam int DIV_W      = 8;
    localparam int IDX_W      = 3;

    // Captured frame layout is {p, d3, d2, d1, d0}; bit 0 arrives first.
    function automatic logic [DATA_BITS-1:0] frame_data(input logic [FRAME_BITS-1:0] frame);
        return frame[DATA_BITS-1:0];
    endfunction

endpackage

// File: rtl/parity_frame_ctrl_if.sv
// ---------------------------------------------------------------------------
// parity_frame_ctrl_if
// Bundles the serial input and the valid/ready result handshake of the
// parity frame controller.
//   start      : source -> ctrl, one-cycle pulse that begins a frame
//   din        : source -> ctrl, serial bit (d0, d1, d2, d3, p)
//   out_ready  : consumer -> ctrl, consumer accepts the result
//   busy       : ctrl -> source, controller not in IDLE
//   out_valid  : ctrl -> consumer, result available
//   out_data   : ctrl -> consumer, captured nibble {d3,d2,d1,d0}
//   parity_err : ctrl -> consumer, even parity violated
//   err_count  : ctrl -> consumer, saturating count of bad frames
// Modports: master = the board side (source + consumer), slave = controller.
// ---------------------------------------------------------------------------
interface parity_frame_ctrl_if
    import parity_pkg::*;
#(
    parameter int ERR_CNT_W = 8
);

    logic                 start;
    logic                 din;
    logic                 out_ready;
    logic                 busy;
    logic                 out_valid;
    logic [DATA_BITS-1:0] out_data;
    logic                 parity_err;
    logic [ERR_CNT_W-1:0] err_count;

    modport master (
        output start,
        output din,
        output out_ready,
        input  busy,
        input  out_valid,
        input  out_data,
        input  parity_err,
        input  err_count
    );

    modport slave (
        input  start,
        input  din,
        input  out_ready,
        output busy,
        output out_valid,
        output out_data,
        output parity_err,
        output err_count
    );

endinterface

// File: rtl/parity_frame_ctrl_checker.sv
// ---------------------------------------------------------------------------
// parity_frame_ctrl_checker
// Five-input XOR parity checker used by the frame controller.
//   a, b, c, d : data bits d0..d3
//   p          : parity bit
//   e          : 1 when the five inputs hold an odd number of ones
//                (even parity violated)
// ---------------------------------------------------------------------------
module parity_frame_ctrl_checker (
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    input  logic p,
    output logic e
);

    assign e = a ^ b ^ c ^ d ^ p;

endmodule

// File: rtl/parity_frame_ctrl.sv
// ---------------------------------------------------------------------------
// parity_frame_ctrl
// Captures a 5-bit serial frame (d0, d1, d2, d3, p) from din, evaluates it
// with the XOR parity checker and offers {d3..d0} plus a pass/fail flag on a
// valid/ready handshake.
//
// Parameters:
//   BIT_DIV   : clock cycles per serial bit (1..255); din is sampled on the
//               last cycle of each bit period
//   ERR_CNT_W : width of the parity error counter
//
// Ports:
//   clk : system clock, rising edge
//   rst : synchronous active-high reset, overrides everything
//   bus : parity_frame_ctrl_if.slave (start, din, out_ready in;
//         busy, out_valid, out_data, parity_err, err_count out)
//
// Configuration macro:
//   PARITY_ERR_COUNT_EN : when defined, err_count is a saturating counter of
//                         frames with parity errors; when undefined, no
//                         counter is built and err_count is tied to 0.
//
// Timing: start seen in cycle 0, SHIFT spans cycles 1..5*BIT_DIV, CHECK is
// cycle 5*BIT_DIV+1 and out_valid is high from cycle 5*BIT_DIV+2.
// ---------------------------------------------------------------------------
module parity_frame_ctrl
    import parity_pkg::*;
#(
    parameter int BIT_DIV   = 1,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    parity_frame_ctrl_if.slave   bus
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_BITS - 1);

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    state_t                state_q,  state_d;
    logic [DIV_W-1:0]      div_q,    div_d;
    logic [IDX_W-1:0]      idx_q,    idx_d;
    logic [FRAME_BITS-1:0] shift_q,  shift_d;
    logic                  valid_q,  valid_d;
    logic [DATA_BITS-1:0]  data_q,   data_d;
    logic                  perr_q,   perr_d;

    logic                  accept_start;
    logic                  bit_tick;
    logic                  parity_fail;

    // A start is only honoured from IDLE; any other pulse is dropped.
    assign accept_start = (state_q == IDLE) && bus.start;

    // Last cycle of the current bit period while shifting.
    assign bit_tick = (state_q == SHIFT) && (div_q == DIV_LAST);

    // -----------------------------------------------------------------------
    // Parity checker on the captured frame
    // -----------------------------------------------------------------------
    parity_frame_ctrl_checker u_checker (
        .a (shift_q[0]),
        .b (shift_q[1]),
        .c (shift_q[2]),
        .d (shift_q[3]),
        .p (shift_q[4]),
        .e (parity_fail)
    );

    // -----------------------------------------------------------------------
    // Capture register: each position loads din only on the bit tick that
    // addresses it, so earlier samples are never disturbed.
    // -----------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < FRAME_BITS; gi++) begin : g_capture
            logic bit_hit;
            assign bit_hit = bit_tick && (idx_q == IDX_W'(gi));
            assign shift_d[gi] = accept_start ? 1'b0 :
                                 bit_hit      ? bus.din :
                                                shift_q[gi];
        end
    endgenerate

    // -----------------------------------------------------------------------
    // FSM next state and datapath updates
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        data_d  = data_q;
        perr_d  = perr_q;

        case (state_q)
            IDLE: begin
                if (accept_start) begin
                    state_d = SHIFT;
                    div_d   = '0;
                    idx_d   = '0;
                end
            end

            SHIFT: begin
                if (bit_tick) begin
                    div_d = '0;
                    idx_d = idx_q + 1'b1;
                    if (idx_q == IDX_LAST) begin
                        state_d = CHECK;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end

            CHECK: begin
                data_d  = frame_data(shift_q);
                perr_d  = parity_fail;
                valid_d = 1'b1;
                state_d = HOLD;
            end

            HOLD: begin
                // Result stays put until the consumer takes it; data and
                // flag remain visible after the transfer.
                if (valid_q && bus.out_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            div_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            perr_q  <= perr_d;
        end
    end

    // -----------------------------------------------------------------------
    // Parity error counter
    // -----------------------------------------------------------------------
`ifdef PARITY_ERR_COUNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    // Counts failing frames in CHECK and holds at all-ones instead of wrapping.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if ((state_q == CHECK) && parity_fail && !(&err_cnt_q)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.err_count = err_cnt_q;
`else
    assign bus.err_count = {ERR_CNT_W{1'b0}};
`endif

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.busy       = (state_q != IDLE);
    assign bus.out_valid  = valid_q;
    assign bus.out_data   = data_q;
    assign bus.parity_err = perr_q;

endmodule

// File: tb/tb_parity_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_parity_frame_ctrl
// Two controller instances: cfg0 (BIT_DIV=1, ERR_CNT_W=2) and cfg1
// (BIT_DIV=3, ERR_CNT_W=8). A cycle-count model of each frame predicts every
// output every cycle; hand-computed results (latency, nibble, flag, count)
// are queued per frame and checked when out_valid rises.
// ---------------------------------------------------------------------------
module tb_parity_frame_ctrl;

`ifdef PARITY_ERR_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    localparam int NCFG = 2;

    typedef struct {
        int         cyc;
        logic [3:0] data;
        logic       perr;
        int         errc;
    } lit_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rst_s   [NCFG];
    logic       start_s [NCFG];
    logic       din_s   [NCFG];
    logic       ready_s [NCFG];
    logic       busy_w  [NCFG];
    logic       valid_w [NCFG];
    logic       perr_w  [NCFG];
    logic [3:0] data_w  [NCFG];
    logic [7:0] errc_w  [NCFG];

    genvar gi;
    generate
        for (gi = 0; gi < NCFG; gi++) begin : g_cfg
            localparam int BD = (gi == 0) ? 1 : 3;
            localparam int EW = (gi == 0) ? 2 : 8;

            parity_frame_ctrl_if #(.ERR_CNT_W(EW)) bus ();

            assign bus.start     = start_s[gi];
            assign bus.din       = din_s[gi];
            assign bus.out_ready = ready_s[gi];
            assign busy_w[gi]    = bus.busy;
            assign valid_w[gi]   = bus.out_valid;
            assign perr_w[gi]    = bus.parity_err;
            assign data_w[gi]    = bus.out_data;
            assign errc_w[gi]    = 8'(bus.err_count);

            parity_frame_ctrl #(.BIT_DIV(BD), .ERR_CNT_W(EW)) dut (
                .clk (clk),
                .rst (rst_s[gi]),
                .bus (bus.slave)
            );
        end
    endgenerate

    function automatic int div_of(input int c);
        return (c == 0) ? 1 : 3;
    endfunction

    function automatic int errmax_of(input int c);
        return (c == 0) ? 3 : 255;
    endfunction

    // ------------------------------------------------------------------
    // Scoreboard counters, stepped only by check()
    // ------------------------------------------------------------------
    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int c,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s cfg%0d cycle %0d: got %0h, expected %0h",
                         name, c, cyc, act, exp);
        end
    endtask

    lit_t lit_q0[$];
    lit_t lit_q1[$];
    bit   done = 1'b0;

    // ------------------------------------------------------------------
    // Model + compare process. At each falling edge the model reflects all
    // rising edges so far; it is compared, then advanced with the inputs
    // that the next rising edge will sample.
    // ------------------------------------------------------------------
    bit         m_known [NCFG];
    bit         m_busy  [NCFG];
    bit         m_valid [NCFG];
    bit         m_perr  [NCFG];
    int         m_t     [NCFG];
    logic [4:0] m_bits  [NCFG];
    logic [3:0] m_data  [NCFG];
    int         m_errc  [NCFG];
    logic       prev_v  [NCFG];
    bit         final_done = 1'b0;

    initial begin
        for (int c = 0; c < NCFG; c++) begin
            m_known[c] = 1'b0;
            prev_v[c]  = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int c = 0; c < NCFG; c++) begin
                if (m_known[c]) begin
                    check("busy",       c, 32'(busy_w[c]),  32'(m_busy[c]));
                    check("out_valid",  c, 32'(valid_w[c]), 32'(m_valid[c]));
                    check("out_data",   c, 32'(data_w[c]),  32'(m_data[c]));
                    check("parity_err", c, 32'(perr_w[c]),  32'(m_perr[c]));
                    check("err_count",  c, 32'(errc_w[c]),  32'(m_errc[c]));

                    if (valid_w[c] === 1'b1 && prev_v[c] !== 1'b1) begin
                        lit_t e;
                        int   n;
                        n = (c == 0) ? lit_q0.size() : lit_q1.size();
                        if (n == 0) begin
                            check("unexpected_valid", c, 32'd1, 32'd0);
                        end else begin
                            e = (c == 0) ? lit_q0.pop_front() : lit_q1.pop_front();
                            check("valid_latency", c, 32'(cyc),     32'(e.cyc));
                            check("lit_data",      c, 32'(data_w[c]), 32'(e.data));
                            check("lit_perr",      c, 32'(perr_w[c]), 32'(e.perr));
                            check("lit_errc",      c, 32'(errc_w[c]), 32'(e.errc));
                        end
                    end
                end
                prev_v[c] = valid_w[c];

                // Advance the model over the coming rising edge.
                if (rst_s[c] === 1'b1) begin
                    m_known[c] = 1'b1;
                    m_busy[c]  = 1'b0;
                    m_valid[c] = 1'b0;
                    m_perr[c]  = 1'b0;
                    m_t[c]     = 0;
                    m_bits[c]  = '0;
                    m_data[c]  = '0;
                    m_errc[c]  = 0;
                end else if (!m_busy[c]) begin
                    if (start_s[c] === 1'b1) begin
                        m_busy[c] = 1'b1;
                        m_t[c]    = 0;
                        m_bits[c] = '0;
                    end
                end else if (!m_valid[c]) begin
                    int d;
                    d      = div_of(c);
                    m_t[c] = m_t[c] + 1;
                    if ((m_t[c] % d) == 0 && (m_t[c] / d) >= 1 && (m_t[c] / d) <= 5)
                        m_bits[c][(m_t[c] / d) - 1] = din_s[c];
                    if (m_t[c] == 5 * d + 1) begin
                        m_valid[c] = 1'b1;
                        m_data[c]  = m_bits[c][3:0];
                        m_perr[c]  = ^m_bits[c];
                        if (CNT_EN && m_perr[c] && m_errc[c] < errmax_of(c))
                            m_errc[c] = m_errc[c] + 1;
                    end
                end else if (ready_s[c] === 1'b1) begin
                    m_valid[c] = 1'b0;
                    m_busy[c]  = 1'b0;
                end
            end
            if (done && !final_done) begin
                final_done = 1'b1;
                check("pending_results", 0, 32'(lit_q0.size()), 32'd0);
                check("pending_results", 1, 32'(lit_q1.size()), 32'd0);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Starts a frame in the current cycle and shifts d0..d3, p. Returns in
    // the CHECK cycle. Expected values are supplied by the caller.
    task automatic send_frame(input int c, input logic [3:0] d, input logic p,
                              input logic exp_perr, input int exp_errc,
                              input int exp_lat);
        lit_t       e;
        logic [4:0] bits;
        int         s;
        bits       = {p, d};
        s          = cyc;
        e.cyc      = s + exp_lat;
        e.data     = d;
        e.perr     = exp_perr;
        e.errc     = CNT_EN ? exp_errc : 0;
        if (c == 0) lit_q0.push_back(e);
        else        lit_q1.push_back(e);
        $display("frame cfg%0d: d=%b p=%b start@%0d expect perr=%0d errc=%0d valid@%0d",
                 c, d, p, s, exp_perr, e.errc, e.cyc);
        start_s[c] = 1'b1;
        step(1);
        start_s[c] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            din_s[c] = bits[k];
            step(div_of(c));
        end
        din_s[c] = 1'b0;
    endtask

    initial begin
        for (int c = 0; c < NCFG; c++) begin
            rst_s[c]   = 1'b1;
            start_s[c] = 1'b0;
            din_s[c]   = 1'b0;
            ready_s[c] = 1'b1;
        end
        step(2);
        for (int c = 0; c < NCFG; c++) rst_s[c] = 1'b0;
        step(2);

        // cfg0: good frame
        send_frame(0, 4'b1101, 1'b1, 1'b0, 0, 7);
        step(2);

        // cfg0: bad frame, start pulse during the transfer cycle is ignored,
        // next frame starts in the first IDLE cycle.
        send_frame(0, 4'b0001, 1'b0, 1'b1, 1, 7);
        step(1);
        start_s[0] = 1'b1;
        step(1);
        ready_s[0] = 1'b0;

        // cfg0: backpressure with a start pulse in the hold window
        send_frame(0, 4'b0110, 1'b0, 1'b0, 1, 7);
        step(1);
        for (int i = 0; i < 10; i++) begin
            start_s[0] = (i == 3);
            step(1);
        end
        start_s[0] = 1'b0;
        ready_s[0] = 1'b1;
        step(2);

        // cfg0: reset after two bits have been sampled
        $display("reset mid-frame cfg0 at %0d", cyc);
        start_s[0] = 1'b1;
        step(1);
        start_s[0] = 1'b0;
        din_s[0]   = 1'b1;
        step(2);
        rst_s[0]   = 1'b1;
        step(1);
        rst_s[0]   = 1'b0;
        din_s[0]   = 1'b0;
        step(1);
        send_frame(0, 4'b1111, 1'b0, 1'b0, 0, 7);
        step(2);

        // cfg0: saturation of the 2-bit counter
        for (int k = 1; k <= 5; k++) begin
            send_frame(0, 4'b0011, 1'b1, 1'b1, (k > 3) ? 3 : k, 7);
            step(2);
        end

        // cfg1: divider of 3
        send_frame(1, 4'b0101, 1'b0, 1'b0, 0, 17);
        step(2);
        send_frame(1, 4'b0100, 1'b0, 1'b1, 1, 17);
        step(2);

        done = 1'b1;
        step(3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
